// File: rtl/td4_out_uart.sv
// TD4 output-port monitor: queues each change of outp_in and sends it as an ASCII
// hex character on a UART 8N1 line. Define TD4_OUT_CRLF_EN to follow each character with CR LF.
module td4_out_uart #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    outp_in,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [1:0]                    state_dbg
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           tx_q, tx_d;
    logic [3:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count_q;
    logic [3:0]     prev_q;
    logic           ovf_q;
    logic           push_req, push_ok, pop;
    logic           baud_last;
    logic           term_pending;

`ifdef TD4_OUT_CRLF_EN
    // Number of line-terminator frames still owed for the current value (2 = CR then LF).
    logic [1:0]     tail_q, tail_d;
    assign term_pending = (tail_q != 2'd0);
`else
    assign term_pending = 1'b0;
`endif

    function automatic logic [7:0] hex_char(input logic [3:0] v);
        if (v < 4'd10)
            return 8'h30 + {4'h0, v};
        else
            return 8'h41 + ({4'h0, v} - 8'd10);
    endfunction

    assign push_req  = (outp_in != prev_q);
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    assign push_ok   = push_req && ((count_q < CW'(FIFO_DEPTH)) || pop);
    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef TD4_OUT_CRLF_EN
        tail_d  = tail_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = '0;
`ifdef TD4_OUT_CRLF_EN
                if (tail_q != 2'd0) begin
                    shreg_d = (tail_q == 2'd2) ? 8'h0D : 8'h0A;
                    tail_d  = tail_q - 2'd1;
                    tx_d    = 1'b0;
                    state_d = START;
                end else if (count_q != '0) begin
                    pop     = 1'b1;
                    shreg_d = hex_char(mem[rd_ptr]);
                    tail_d  = 2'd2;
                    tx_d    = 1'b0;
                    state_d = START;
                end
`else
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shreg_d = hex_char(mem[rd_ptr]);
                    tx_d    = 1'b0;
                    state_d = START;
                end
`endif
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Shift register already holds the next bit at position 0.
                        tx_d    = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            prev_q  <= 4'h0;
            ovf_q   <= 1'b0;
`ifdef TD4_OUT_CRLF_EN
            tail_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
`ifdef TD4_OUT_CRLF_EN
            tail_q  <= tail_d;
`endif
            if (push_req)
                prev_q <= outp_in;
            if (push_req && !push_ok)
                ovf_q <= 1'b1;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (reset && push_ok)
            mem[wr_ptr] <= outp_in;
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) || (count_q != '0) || term_pending;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_td4_out_uart.sv
// Directed bench for td4_out_uart: table of values with their expected hex characters,
// plus hand-written sequences for reset idle, FIFO overflow and reset mid-frame.
module tb_td4_out_uart;

    localparam int C        = 4;
    localparam int D        = 4;
    localparam int FL       = 10 * C;
    localparam int WAIT_MAX = 3000;

    logic                 clk;
    logic                 reset;
    logic [3:0]           outp_in;
    logic                 tx;
    logic                 busy;
    logic                 overflow;
    logic [$clog2(D):0]   fifo_count;
    logic [1:0]           state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [3:0] val;
        logic [7:0] ch;
    } vec_t;

    vec_t vecs[6];

    td4_out_uart #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .outp_in    (outp_in),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_expected(input logic [7:0] ch);
        exp_q.push_back(ch);
`ifdef TD4_OUT_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    // Wait for a start bit, capture a whole frame sampled at negedges, compare to exp_q head.
    task automatic expect_frame(input string name, input int exp_gap);
        logic [7:0] exp_ch;
        logic [7:0] ch;
        logic       s[FL];
        logic       lvl;
        int         gap;
        int         bad;
        exp_ch = exp_q.pop_front();
        gap = 0;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) break;
            gap++;
            if (gap > WAIT_MAX) break;
        end
        if (gap > WAIT_MAX) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no start bit within %0d cycles, expected char %02h", name, WAIT_MAX, exp_ch);
            return;
        end
        s[0] = tx;
        for (int i = 1; i < FL; i++) begin
            @(negedge clk);
            s[i] = tx;
        end
        for (int i = 0; i < 8; i++)
            ch[i] = s[(i + 1) * C + C / 2];
        bad = 0;
        for (int b = 0; b < 10; b++) begin
            lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : ch[b - 1];
            for (int k = 0; k < C; k++)
                if (s[b * C + k] !== lvl) bad++;
        end
        check({name, "_char"}, {24'h0, ch}, {24'h0, exp_ch});
        check({name, "_shape"}, bad, 0);
        if (exp_gap >= 0)
            check({name, "_gap"}, gap, exp_gap);
    endtask

    initial begin
        int bad;
        int exp_cnt[5];

        vecs[0] = '{val: 4'h5, ch: 8'h35};
        vecs[1] = '{val: 4'hA, ch: 8'h41};
        vecs[2] = '{val: 4'h0, ch: 8'h30};
        vecs[3] = '{val: 4'h9, ch: 8'h39};
        vecs[4] = '{val: 4'hF, ch: 8'h46};
        vecs[5] = '{val: 4'h3, ch: 8'h33};
        exp_cnt = '{1, 1, 2, 3, 4};

        // reset state
        reset   = 1'b0;
        outp_in = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_count", fifo_count, 0);
        reset = 1'b1;

        // table-driven character vectors
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            outp_in = vecs[v].val;
            push_expected(vecs[v].ch);
            @(negedge clk);
            check("vec_count", fifo_count, 1);
            check("vec_tx_pre", tx, 1);
            check("vec_busy", busy, 1);
            expect_frame("vec", 0);
`ifdef TD4_OUT_CRLF_EN
            expect_frame("vec_cr", 1);
            expect_frame("vec_lf", 1);
`endif
            @(negedge clk);
            check("vec_busy_end", busy, 0);
            check("vec_tx_end", tx, 1);
        end

        // held value produces no further frames
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("hold_idle", bad, 0);

        // reset held then released with outp_in = 0: silent line
        reset   = 1'b0;
        outp_in = 4'h0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== '0) bad++;
        end
        check("idle_after_reset", bad, 0);

        // FIFO fill and overflow: 1..6 on consecutive cycles, 6 is dropped
        for (int i = 1; i <= 5; i++)
            push_expected(8'h30 + 8'(i));
        fork
            begin
                @(negedge clk);
                outp_in = 4'd1;
                for (int i = 2; i <= 6; i++) begin
                    @(negedge clk);
                    check("fifo_count", fifo_count, exp_cnt[i - 2]);
                    if (i == 6)
                        check("fifo_ovf_before", overflow, 0);
                    outp_in = 4'(i);
                end
                @(negedge clk);
                check("fifo_count_peak", fifo_count, 4);
                check("fifo_ovf_set", overflow, 1);
            end
            begin
                expect_frame("fifo", -1);
                while (exp_q.size() > 0)
                    expect_frame("fifo", 1);
            end
        join
        @(negedge clk);
        check("fifo_busy_end", busy, 0);
        check("fifo_ovf_sticky", overflow, 1);

        // reset in the middle of a data bit with entries still queued
        @(negedge clk);
        outp_in = 4'h8;
        @(negedge clk);
        outp_in = 4'h9;
        @(negedge clk);
        outp_in = 4'hA;
        repeat (3 * C) @(negedge clk);
        check("mid_tx_low", tx, 0);
        check("mid_count", fifo_count, 2);
        reset   = 1'b0;
        outp_in = 4'h0;
        @(negedge clk);
        check("abort_tx", tx, 1);
        check("abort_count", fifo_count, 0);
        check("abort_ovf", overflow, 0);
        check("abort_busy", busy, 0);
        reset = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("abort_idle", bad, 0);
        outp_in = 4'h3;
        push_expected(8'h33);
        expect_frame("post_abort", 1);
`ifdef TD4_OUT_CRLF_EN
        expect_frame("post_abort_cr", 1);
        expect_frame("post_abort_lf", 1);
`endif
        @(negedge clk);
        check("post_abort_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/td4_out_uart.md
Name: td4_out_uart

Overview:
- Downstream stage of the TD4 CPU top; consumes the 4-bit output port (`outp`).
- Detects each change of the port value and queues it in a small FIFO.
- Transmits each queued value as one ASCII hex character ('0'-'9', 'A'-'F') over a UART 8N1 TX line, so program output can be watched on a host terminal.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal values ≥2.
- FIFO_DEPTH, 4, FIFO entries; must be a power of two, ≥2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset.
- outp_in  input  4  CPU output port value.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high while the FIFO is non-empty or a frame is in progress.
- overflow  output  1  sticky; set when a change is dropped because the FIFO is full.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.

Behaviour:
- Reset (reset==0 at a rising edge) sets:
  - tx=1, busy=0, overflow=0, fifo_count=0;
  - prev=4'h0, FSM=IDLE, bit and baud counters=0.
- Reset during a frame aborts it: tx=1 from the next edge, FIFO contents discarded.
- Change detect, every edge: if outp_in != prev, then prev<=outp_in and a push of outp_in is requested.
  - No push when the value is unchanged, including the first cycle after reset with outp_in==0.
- Push is accepted if fifo_count<FIFO_DEPTH, or if a pop happens in the same cycle.
  - Otherwise the value is dropped and overflow<=1.
  - overflow stays set until reset.
- FIFO: circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - fifo_count is +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
- Character encoding: v<10 → 8'h30+v; v≥10 → 8'h41+(v-10).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if fifo_count!=0, pop the head, latch the encoded char in the shift register, tx<=0, go to START. Otherwise tx=1.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then tx<=bit0, go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. After bit7, tx<=1, go to STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames: IDLE lasts one cycle between frames.
- Latency: a change sampled at edge N is pushed at N. If the FSM is idle, the pop occurs at N+1 and tx falls after edge N+1.
- busy = (state!=IDLE) | (fifo_count!=0), registered-state based.
- tx is driven only from a register; no glitches.

Optional Feature:
- Macro: TD4_OUT_CRLF_EN.
- Defined: each popped value is sent as three back-to-back frames: hex char, 8'h0D, 8'h0A. The next pop waits until the LF stop bit completes. busy stays high across all three frames.
- Undefined: one frame per value; no line terminators.

Test Plan:
- CLKS_PER_BIT=4; after reset, outp_in 0→5 at edge N.
  - tx falls after N+1.
  - Bits 1,0,1,0,1,1,0,0 (0x35), then stop=1.
  - Frame is 40 cycles; busy drops at the cycle returning to IDLE with an empty FIFO.
- outp_in=4'hA.
  - Char 0x41; bits 1,0,0,0,0,0,1,0.
  - outp_in held at A afterwards → no further frames.
- Reset held, then released with outp_in=0.
  - No frame is sent.
  - tx=1, busy=0, fifo_count=0 for 100 cycles.
- FIFO_DEPTH=4; outp_in=1,2,3,4,5,6 on consecutive cycles.
  - Value 1 popped immediately; fifo_count peaks at 4.
  - 6 dropped; overflow=1.
  - Chars '1','2','3','4','5' transmitted in order.
- Reset asserted mid-DATA of a frame.
  - Next edge: tx=1, fifo_count=0, overflow=0.
  - After release: idle until outp_in changes.
- TD4_OUT_CRLF_EN defined; outp_in 0→F.
  - Frames 0x46, 0x0D, 0x0A back-to-back, 120 cycles at CLKS_PER_BIT=4 plus two one-cycle IDLE gaps.
